// File: rtl/fejkon_fc_pkg.sv
// Shared types and CSR map for the fejkon FC stream arbiter.
package fejkon_fc_pkg;

  localparam int unsigned DATA_W  = 256;
  localparam int unsigned CHAN_W  = 4;
  localparam int unsigned EMPTY_W = 5;
  localparam int unsigned CSR_W   = 32;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [CHAN_W-1:0]  channel;
    logic [EMPTY_W-1:0] empty;
    logic               sop;
    logic               eop;
  } fc_beat_t;

  localparam logic [7:0] CSR_MASK   = 8'h00;
  localparam logic [7:0] CSR_STATUS = 8'h01;
  localparam logic [7:0] CSR_FRAMES = 8'h10;
  localparam logic [7:0] CSR_STALLS = 8'h20;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fejkon_rr_pick.sv
// Combinational rotate-priority picker: first set req bit after last_grant, wrapping.
module fejkon_rr_pick
  import fejkon_fc_pkg::*;
#(
  parameter  int unsigned NUM_IN = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [IDX_W-1:0]  grant,
  output logic              any
);

  int unsigned idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      idx = (32'(last_grant) + k) % NUM_IN;
      if (!any && req[IDX_W'(idx)]) begin
        grant = IDX_W'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fejkon_fc_arbiter.sv
// Packet-aware round-robin merge of NUM_IN Avalon-ST FC streams with a small CSR block.
// Define FEJKON_FC_ARB_STATS_EN to build the per-input frame and stall counters.
module fejkon_fc_arbiter
  import fejkon_fc_pkg::*;
#(
  parameter int unsigned NUM_IN = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IN*DATA_W-1:0]  st_in_data,
  input  logic [NUM_IN*CHAN_W-1:0]  st_in_channel,
  input  logic [NUM_IN*EMPTY_W-1:0] st_in_empty,
  input  logic [NUM_IN-1:0]         st_in_startofpacket,
  input  logic [NUM_IN-1:0]         st_in_endofpacket,
  input  logic [NUM_IN-1:0]         st_in_valid,
  output logic [NUM_IN-1:0]         st_in_ready,
  output logic [DATA_W-1:0]         st_out_data,
  output logic [CHAN_W-1:0]         st_out_channel,
  output logic [EMPTY_W-1:0]        st_out_empty,
  output logic                      st_out_startofpacket,
  output logic                      st_out_endofpacket,
  output logic                      st_out_valid,
  input  logic                      st_out_ready,
  input  logic [7:0]                csr_address,
  input  logic                      csr_write,
  input  logic                      csr_read,
  input  logic [CSR_W-1:0]          csr_writedata,
  output logic [CSR_W-1:0]          csr_readdata
);

  localparam int unsigned IDX_W = $clog2(NUM_IN);

  arb_state_t        state, state_next;
  logic [IDX_W-1:0]  grant, grant_next, last_grant, last_grant_next;
  logic [IDX_W-1:0]  pick_grant;
  logic              pick_any;
  logic [NUM_IN-1:0] mask, req;
  fc_beat_t          sel_beat;
  logic              sel_valid, out_load, accept;
  logic [CSR_W-1:0]  rd_next;
  logic              unused_wdata;

  assign unused_wdata = ^csr_writedata[CSR_W-1:NUM_IN];
  assign req          = st_in_valid & mask & st_in_startofpacket;
  assign out_load     = ~st_out_valid | st_out_ready;
  assign accept       = (state == ST_PASS) && out_load && sel_valid;

  fejkon_rr_pick #(.NUM_IN(NUM_IN)) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .any        (pick_any)
  );

  // Beat mux from the granted input
  always_comb begin
    sel_beat.data    = st_in_data[32'(grant)*DATA_W +: DATA_W];
    sel_beat.channel = st_in_channel[32'(grant)*CHAN_W +: CHAN_W];
    sel_beat.empty   = st_in_empty[32'(grant)*EMPTY_W +: EMPTY_W];
    sel_beat.sop     = st_in_startofpacket[grant];
    sel_beat.eop     = st_in_endofpacket[grant];
    sel_valid        = st_in_valid[grant];
  end

  always_comb begin
    st_in_ready = '0;
    if (state == ST_PASS && out_load) st_in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_IN - 1);
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
    end
  end

  // Grant is latched on SOP and held until the EOP beat is accepted
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          grant_next = pick_grant;
          state_next = ST_PASS;
        end
      end
      ST_PASS: begin
        if (accept && sel_beat.eop) begin
          last_grant_next = grant;
          state_next      = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_out_valid         <= 1'b0;
      st_out_data          <= '0;
      st_out_channel       <= '0;
      st_out_empty         <= '0;
      st_out_startofpacket <= 1'b0;
      st_out_endofpacket   <= 1'b0;
    end else if (out_load) begin
      st_out_valid <= accept;
      if (accept) begin
        st_out_data          <= sel_beat.data;
        st_out_channel       <= sel_beat.channel;
        st_out_empty         <= sel_beat.empty;
        st_out_startofpacket <= sel_beat.sop;
        st_out_endofpacket   <= sel_beat.eop;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mask <= '1;
    else if (csr_write && csr_address == CSR_MASK) mask <= csr_writedata[NUM_IN-1:0];
  end

`ifdef FEJKON_FC_ARB_STATS_EN
  logic [CSR_W-1:0] frames [NUM_IN];
  logic [CSR_W-1:0] stalls [NUM_IN];

  // Frame counters wrap; stall counters saturate and clear on any write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_IN; i++) begin
        frames[i] <= '0;
        stalls[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (st_in_valid[i] && st_in_ready[i] && st_in_endofpacket[i])
          frames[i] <= frames[i] + 32'd1;
        if (csr_write && csr_address == CSR_STALLS + 8'(i))
          stalls[i] <= '0;
        else if (st_in_valid[i] && !st_in_ready[i] && stalls[i] != '1)
          stalls[i] <= stalls[i] + 32'd1;
      end
    end
  end
`endif

  always_comb begin
    rd_next = '1;
    if (csr_address == CSR_MASK) begin
      rd_next = CSR_W'(mask);
    end else if (csr_address == CSR_STATUS) begin
      rd_next              = '0;
      rd_next[CSR_W-1]     = (state == ST_PASS);
      rd_next[IDX_W-1:0]   = grant;
    end
`ifdef FEJKON_FC_ARB_STATS_EN
    for (int i = 0; i < NUM_IN; i++) begin
      if (csr_address == CSR_FRAMES + 8'(i)) rd_next = frames[i];
      if (csr_address == CSR_STALLS + 8'(i)) rd_next = stalls[i];
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) csr_readdata <= '0;
    else if (csr_read) csr_readdata <= rd_next;
  end

endmodule

// File: tb/tb_fejkon_fc_arbiter.sv
// Directed self-checking bench for fejkon_fc_arbiter (4 inputs).
module tb_fejkon_fc_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*256-1:0] st_in_data;
  logic [N*4-1:0] st_in_channel;
  logic [N*5-1:0] st_in_empty;
  logic [N-1:0]   st_in_startofpacket, st_in_endofpacket, st_in_valid, st_in_ready;
  logic [255:0]   st_out_data;
  logic [3:0]     st_out_channel;
  logic [4:0]     st_out_empty;
  logic           st_out_startofpacket, st_out_endofpacket, st_out_valid, st_out_ready;
  logic [7:0]     csr_address;
  logic           csr_write, csr_read;
  logic [31:0]    csr_writedata, csr_readdata;

  fejkon_fc_arbiter #(.NUM_IN(N)) dut (
    .clk(clk), .reset(reset),
    .st_in_data(st_in_data), .st_in_channel(st_in_channel), .st_in_empty(st_in_empty),
    .st_in_startofpacket(st_in_startofpacket), .st_in_endofpacket(st_in_endofpacket),
    .st_in_valid(st_in_valid), .st_in_ready(st_in_ready),
    .st_out_data(st_out_data), .st_out_channel(st_out_channel), .st_out_empty(st_out_empty),
    .st_out_startofpacket(st_out_startofpacket), .st_out_endofpacket(st_out_endofpacket),
    .st_out_valid(st_out_valid), .st_out_ready(st_out_ready),
    .csr_address(csr_address), .csr_write(csr_write), .csr_read(csr_read),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int src_len [N];
  int src_left [N];
  int src_beat [N];
  int src_fnum [N];
  logic [N-1:0] acc;
  int ready_bad, hold_bad, hold_seen;
  logic hold_pend;
  logic [33:0] hold_val;
  logic [31:0] rx_tag [$];
  logic [3:0]  rx_chan [$];
  logic        rx_sop [$];
  int          rx_cyc [$];

  function automatic logic [31:0] tag(int i, int f, int b);
    return {8'hA5, 8'(i), 8'(f), 8'(b)};
  endfunction

  task automatic drive_sources();
    for (int i = 0; i < N; i++) begin
      st_in_valid[i]         = src_left[i] > 0;
      st_in_data[i*256 +: 256] = {8{tag(i, src_fnum[i], src_beat[i])}};
      st_in_channel[i*4 +: 4] = 4'(i);
      st_in_empty[i*5 +: 5]  = 5'(src_beat[i]);
      st_in_startofpacket[i] = src_beat[i] == 0;
      st_in_endofpacket[i]   = src_beat[i] == src_len[i] - 1;
    end
  endtask

  task automatic src_start(input int i, input int len, input int frames);
    src_len[i] = len; src_left[i] = frames; src_beat[i] = 0; src_fnum[i] = 0;
    drive_sources();
  endtask

  task automatic src_clear();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 1; src_left[i] = 0; src_beat[i] = 0; src_fnum[i] = 0;
    end
    drive_sources();
  endtask

  task automatic rx_clear();
    rx_tag.delete(); rx_chan.delete(); rx_sop.delete(); rx_cyc.delete();
    ready_bad = 0; hold_bad = 0; hold_seen = 0; hold_pend = 1'b0; acc = '0;
  endtask

  // One clock: sample at negedge, advance sources just after posedge
  task automatic step();
    @(negedge clk);
    acc = st_in_valid & st_in_ready;
    if ($countones(st_in_ready) > 1) ready_bad++;
    if (hold_pend && (!st_out_valid ||
        {st_out_data[31:0], st_out_startofpacket, st_out_endofpacket} !== hold_val)) hold_bad++;
    hold_pend = st_out_valid && !st_out_ready;
    if (hold_pend) hold_seen++;
    hold_val = {st_out_data[31:0], st_out_startofpacket, st_out_endofpacket};
    if (st_out_valid && st_out_ready) begin
      rx_tag.push_back(st_out_data[31:0]);
      rx_chan.push_back(st_out_channel);
      rx_sop.push_back(st_out_startofpacket);
      rx_cyc.push_back(cyc);
    end
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (src_beat[i] == src_len[i] - 1) begin
          src_beat[i] = 0; src_left[i]--; src_fnum[i]++;
        end else begin
          src_beat[i]++;
        end
      end
    end
    drive_sources();
  endtask

  task automatic csr_rd(input logic [7:0] addr, output logic [31:0] d);
    csr_address = addr; csr_read = 1'b1;
    step();
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic csr_wr(input logic [7:0] addr, input logic [31:0] d);
    csr_address = addr; csr_writedata = d; csr_write = 1'b1;
    step();
    csr_write = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    src_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [31:0] sop_order();
    logic [31:0] o = '0;
    for (int k = 0; k < rx_tag.size(); k++)
      if (rx_sop[k]) o = (o << 4) | 32'(rx_tag[k][23:16]);
    return o;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    apply_reset();
    checks++; if (st_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", st_out_valid); end
    checks++; if (st_in_ready !== '0) begin errors++; $display("FAIL reset_in_ready got %b want 0000", st_in_ready); end
    checks++; if (st_out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", st_out_data[31:0]); end
    checks++; if (csr_readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h want 0", csr_readdata); end
    csr_rd(8'h00, d);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL reset_mask got %h want f", d); end
    csr_rd(8'h01, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", d); end
    csr_rd(8'h05, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL unmapped_read got %h want ffffffff", d); end
  endtask

  task automatic test_two_frames();
    logic [31:0] exp [4];
    logic [31:0] got;
    rx_clear();
    st_out_ready = 1'b1;
    src_start(0, 2, 1);
    src_start(2, 2, 1);
    for (int n = 0; n < 30 && rx_tag.size() < 4; n++) step();
    exp = '{tag(0,0,0), tag(0,0,1), tag(2,0,0), tag(2,0,1)};
    checks++; if (rx_tag.size() != 4) begin errors++; $display("FAIL two_count got %0d want 4", rx_tag.size()); end
    for (int k = 0; k < 4; k++) begin
      got = (k < rx_tag.size()) ? rx_tag[k] : 32'hDEAD_DEAD;
      checks++; if (got !== exp[k]) begin errors++; $display("FAIL two_beat%0d got %h want %h", k, got, exp[k]); end
    end
    if (rx_tag.size() == 4) begin
      checks++; if (rx_chan[2] !== 4'd2) begin errors++; $display("FAIL two_channel got %0d want 2", rx_chan[2]); end
      checks++; if (rx_cyc[2] - rx_cyc[1] != 2) begin errors++; $display("FAIL two_gap got %0d want 2", rx_cyc[2] - rx_cyc[1]); end
    end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL two_ready_onehot got %0d want 0", ready_bad); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d, got;
    rx_clear();
    st_out_ready = 1'b1;
    src_start(1, 4, 1);
    for (int n = 0; n < 40 && rx_tag.size() < 4; n++) begin
      step();
      st_out_ready = ~st_out_ready;
    end
    st_out_ready = 1'b1;
    checks++; if (rx_tag.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", rx_tag.size()); end
    for (int k = 0; k < 4; k++) begin
      got = (k < rx_tag.size()) ? rx_tag[k] : 32'hDEAD_DEAD;
      checks++; if (got !== tag(1,0,k)) begin errors++; $display("FAIL bp_beat%0d got %h want %h", k, got, tag(1,0,k)); end
    end
    checks++; if (hold_bad != 0 || hold_seen == 0) begin errors++; $display("FAIL bp_hold got bad=%0d seen=%0d want bad=0 seen>0", hold_bad, hold_seen); end
    step();
    csr_rd(8'h11, d);
`ifdef FEJKON_FC_ARB_STATS_EN
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL bp_frames1 got %h want 1", d); end
`else
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bp_frames1 got %h want ffffffff", d); end
`endif
  endtask

  task automatic test_round_robin();
    int gap_bad = 0;
    apply_reset();
    rx_clear();
    st_out_ready = 1'b1;
    for (int i = 0; i < N; i++) src_start(i, 2, 2);
    for (int n = 0; n < 80 && rx_tag.size() < 16; n++) step();
    checks++; if (sop_order() !== 32'h0123_0123) begin errors++; $display("FAIL rr_order got %h want 01230123", sop_order()); end
    for (int k = 1; k < rx_tag.size(); k++)
      if (rx_sop[k] && rx_cyc[k] - rx_cyc[k-1] != 2) gap_bad++;
    checks++; if (gap_bad != 0 || rx_tag.size() != 16) begin errors++; $display("FAIL rr_gap got bad=%0d beats=%0d want 0/16", gap_bad, rx_tag.size()); end
  endtask

  task automatic test_mask();
    logic [31:0] d;
    rx_clear();
    st_out_ready = 1'b1;
    src_start(1, 4, 2);
    for (int n = 0; n < 10 && !acc[1]; n++) step();
    src_start(0, 2, 1);
    src_start(2, 2, 1);
    src_start(3, 2, 1);
    csr_wr(8'h00, 32'h5);
    for (int n = 0; n < 40; n++) step();
    checks++; if (rx_tag.size() != 8) begin errors++; $display("FAIL mask_count got %0d want 8", rx_tag.size()); end
    checks++; if (sop_order() !== 32'h120) begin errors++; $display("FAIL mask_order got %h want 120", sop_order()); end
    checks++; if (src_left[1] != 1 || src_left[3] != 1) begin errors++; $display("FAIL mask_excluded got left1=%0d left3=%0d want 1/1", src_left[1], src_left[3]); end
    src_clear();
    csr_rd(8'h00, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL mask_read got %h want 5", d); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    rx_clear();
    st_out_ready = 1'b1;
    src_start(0, 3, 1);
    for (int n = 0; n < 20 && !(st_out_valid && st_out_data[7:0] == 8'd1); n++) step();
    checks++; if (!(st_out_valid && st_out_data[7:0] == 8'd1)) begin errors++; $display("FAIL areset_setup got valid=%0b beat=%0d want 1/1", st_out_valid, st_out_data[7:0]); end
    #2 reset = 1'b1;
    #1;
    checks++; if (st_out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %0b want 0", st_out_valid); end
    checks++; if (st_in_ready !== '0) begin errors++; $display("FAIL areset_ready got %b want 0000", st_in_ready); end
    src_clear();
    step();
    step();
    reset = 1'b0;
    csr_rd(8'h01, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL areset_status got %h want 0", d); end
    csr_rd(8'h00, d);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL areset_mask got %h want f", d); end
  endtask

  task automatic test_stats();
    logic [31:0] d;
    rx_clear();
    st_out_ready = 1'b1;
    src_start(0, 10, 1);
    for (int n = 0; n < 10 && !acc[0]; n++) step();
    src_start(3, 1, 1);
    for (int n = 0; n < 40 && rx_tag.size() < 11; n++) step();
    checks++; if (rx_tag.size() != 11 || sop_order() !== 32'h03) begin errors++; $display("FAIL stats_traffic got beats=%0d order=%h want 11/03", rx_tag.size(), sop_order()); end
    csr_rd(8'h23, d);
`ifdef FEJKON_FC_ARB_STATS_EN
    checks++; if (d < 32'd10 || d === 32'hFFFF_FFFF) begin errors++; $display("FAIL stats_stall3 got %h want >=10", d); end
    csr_rd(8'h10, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL stats_frames0 got %h want 1", d); end
    csr_wr(8'h23, 32'h0);
    csr_rd(8'h23, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL stats_clear got %h want 0", d); end
`else
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stats_stall3 got %h want ffffffff", d); end
    csr_rd(8'h10, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stats_frames0 got %h want ffffffff", d); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    st_out_ready = 1'b0;
    csr_address = '0; csr_write = 1'b0; csr_read = 1'b0; csr_writedata = '0;
    rx_clear();
    src_clear();
    test_reset();
    test_two_frames();
    test_backpressure();
    test_round_robin();
    test_mask();
    test_async_reset();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
